// File: rtl/apb_cmd_fifo_if.sv
// rtl/apb_cmd_fifo_if.sv - producer, consumer and status signals of the APB command FIFO
interface apb_cmd_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4,
  localparam int CMD_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1,
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1
);
  logic [CMD_WIDTH-1:0] s_cmd;
  logic                 s_vld;
  logic                 s_rdy;
  logic                 en;
  logic [CMD_WIDTH-1:0] cmd_in;
  logic                 cmd_vld;
  logic                 cmd_rdy;
  logic                 transfer;
  logic [CNT_WIDTH-1:0] count;
  logic                 full;
  logic                 empty;

  modport master (
    output s_cmd, s_vld, en, cmd_rdy,
    input  s_rdy, cmd_in, cmd_vld, transfer, count, full, empty
  );

  modport slave (
    input  s_cmd, s_vld, en, cmd_rdy,
    output s_rdy, cmd_in, cmd_vld, transfer, count, full, empty
  );
endinterface

// File: rtl/apb_cmd_fifo.sv
// rtl/apb_cmd_fifo.sv - show-ahead command FIFO feeding the APB master
module apb_cmd_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4,
  localparam int CMD_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1
) (
  input  logic               clk,
  input  logic               rst,
  apb_cmd_fifo_if.slave      bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CMD_WIDTH-1:0] mem_q [DEPTH];
  logic                 full, empty, push, pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  always_comb begin
    full     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    push     = bus.s_vld && !full;
    pop      = !empty && bus.cmd_rdy;
    wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left uncleared; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.s_cmd;
    end
  end

  always_comb begin
    bus.s_rdy    = !full;
    bus.cmd_vld  = !empty;
    bus.cmd_in   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    bus.transfer = bus.en && !empty;
    bus.count    = wr_ptr_q - rd_ptr_q;
    bus.full     = full;
    bus.empty    = empty;
  end
endmodule

// File: tb/tb_apb_cmd_fifo.sv
// tb/tb_apb_cmd_fifo.sv - randomized self-checking bench for apb_cmd_fifo
module tb_apb_cmd_fifo;
  localparam int DW    = 32;
  localparam int AWID  = 12;
  localparam int DEPTH = 4;
  localparam int CW    = DW + AWID + 1;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [CW-1:0] model_q [$];
  logic [CW-1:0] exp_out [$];
  logic [CW-1:0] dut_out [$];
  logic [CW-1:0] in_log  [$];

  apb_cmd_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWID), .DEPTH(DEPTH)) bus ();

  apb_cmd_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWID), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of the reference queue; DUT pops are captured as observations.
  task automatic tick();
    bit do_push;
    bit do_pop;
    do_push = !rst && bus.s_vld && (model_q.size() < DEPTH);
    do_pop  = !rst && bus.cmd_rdy && (model_q.size() > 0);
    if (!rst && bus.cmd_vld && bus.cmd_rdy) dut_out.push_back(bus.cmd_in);
    @(posedge clk);
    if (rst) begin
      model_q.delete();
    end else begin
      if (do_pop) exp_out.push_back(model_q.pop_front());
      if (do_push) begin
        model_q.push_back(bus.s_cmd);
        in_log.push_back(bus.s_cmd);
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_logs();
    exp_out.delete();
    dut_out.delete();
    in_log.delete();
  endtask

  function automatic logic [CW-1:0] rand_cmd();
    logic [CW-1:0] w;
    w = {1'($urandom_range(0, 1)), AWID'($urandom), DW'($urandom)};
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; bus.s_vld = 1'b1; bus.s_cmd = rand_cmd(); bus.cmd_rdy = 1'b0; bus.en = 1'b1;
    tick();
    tick();
    rst = 1'b0; bus.s_vld = 1'b0;
    checks++; if (bus.count !== CNTW'(model_q.size())) begin errors++; $display("FAIL reset_count: got %0d want %0d", bus.count, model_q.size()); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.cmd_vld !== 1'b0) begin errors++; $display("FAIL reset_cmd_vld: got %b want 0", bus.cmd_vld); end
    checks++; if (bus.transfer !== 1'b0) begin errors++; $display("FAIL reset_transfer: got %b want 0", bus.transfer); end
    checks++; if (bus.s_rdy !== 1'b1) begin errors++; $display("FAIL reset_s_rdy: got %b want 1", bus.s_rdy); end
    checks++; if (bus.cmd_in !== '0) begin errors++; $display("FAIL reset_cmd_in: got %h want 0", bus.cmd_in); end
  endtask

  task automatic test_fill_drain();
    logic [CW-1:0] w;
    clear_logs();
    bus.cmd_rdy = 1'b0;
    for (int i = 0; i < 16; i += 4) begin
      bus.s_vld = 1'b1;
      bus.s_cmd = {1'b1, AWID'(i), DW'(i)};
      tick();
      if (i == 0) begin
        checks++; if (bus.cmd_vld !== 1'b1 || bus.cmd_in !== bus.s_cmd) begin errors++; $display("FAIL fill_first_visible: got vld=%b cmd=%h want vld=1 cmd=%h", bus.cmd_vld, bus.cmd_in, bus.s_cmd); end
      end
    end
    bus.s_vld = 1'b0;
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", bus.full); end
    checks++; if (bus.s_rdy !== 1'b0) begin errors++; $display("FAIL fill_s_rdy: got %b want 0", bus.s_rdy); end
    checks++; if (bus.count !== CNTW'(DEPTH)) begin errors++; $display("FAIL fill_count: got %0d want %0d", bus.count, DEPTH); end
    bus.cmd_rdy = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    bus.cmd_rdy = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
    checks++; if (dut_out.size() != 4) begin errors++; $display("FAIL drain_pops: got %0d want 4", dut_out.size()); end
    for (int k = 0; k < 4 && k < dut_out.size(); k++) begin
      w = {1'b1, AWID'(4 * k), DW'(4 * k)};
      checks++; if (dut_out[k] !== w) begin errors++; $display("FAIL drain_order[%0d]: got %h want %h", k, dut_out[k], w); end
    end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] blocked;
    clear_logs();
    bus.cmd_rdy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.s_vld = 1'b1; bus.s_cmd = rand_cmd();
      tick();
    end
    blocked = {1'b1, 12'h50A, 32'hAAAA_AAAA};
    bus.s_vld = 1'b1; bus.s_cmd = blocked; bus.cmd_rdy = 1'b1;
    checks++; if (bus.s_rdy !== 1'b0) begin errors++; $display("FAIL bp_s_rdy_full: got %b want 0", bus.s_rdy); end
    tick();
    bus.s_vld = 1'b0; bus.cmd_rdy = 1'b0;
    checks++; if (bus.count !== CNTW'(model_q.size())) begin errors++; $display("FAIL bp_count: got %0d want %0d", bus.count, model_q.size()); end
    checks++; if (bus.s_rdy !== 1'b1) begin errors++; $display("FAIL bp_s_rdy_after: got %b want 1", bus.s_rdy); end
    bus.cmd_rdy = 1'b1;
    for (int k = 0; k < DEPTH; k++) tick();
    bus.cmd_rdy = 1'b0;
    checks++; if (dut_out.size() != DEPTH) begin errors++; $display("FAIL bp_drained: got %0d want %0d", dut_out.size(), DEPTH); end
    for (int k = 0; k < dut_out.size() && k < exp_out.size(); k++) begin
      checks++; if (dut_out[k] !== exp_out[k] || dut_out[k] === blocked) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", k, dut_out[k], exp_out[k]); end
    end
  endtask

  task automatic test_concurrent();
    clear_logs();
    bus.cmd_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.s_vld = 1'b1; bus.s_cmd = rand_cmd();
      tick();
    end
    bus.cmd_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.s_vld = 1'b1; bus.s_cmd = rand_cmd();
      tick();
      checks++; if (bus.count !== 2'd2) begin errors++; $display("FAIL conc_count[%0d]: got %0d want 2", k, bus.count); end
    end
    bus.s_vld = 1'b0;
    for (int k = 0; k < 2; k++) tick();
    bus.cmd_rdy = 1'b0;
    checks++; if (dut_out.size() != in_log.size()) begin errors++; $display("FAIL conc_len: got %0d want %0d", dut_out.size(), in_log.size()); end
    for (int k = 0; k < dut_out.size() && k < in_log.size(); k++) begin
      checks++; if (dut_out[k] !== in_log[k]) begin errors++; $display("FAIL conc_seq[%0d]: got %h want %h", k, dut_out[k], in_log[k]); end
    end
  endtask

  task automatic test_wrap();
    int pushed;
    int cyc;
    bit accepted;
    logic [CW-1:0] w;
    clear_logs();
    pushed = 0;
    cyc = 0;
    while (dut_out.size() < 10 && cyc < 300) begin
      if (pushed < 10) begin
        bus.s_vld = 1'b1;
        bus.s_cmd = {1'b0, AWID'(4 * pushed), DW'(0)};
      end else begin
        bus.s_vld = 1'b0;
      end
      bus.cmd_rdy = 1'($urandom_range(0, 1));
      accepted = bus.s_vld && (model_q.size() < DEPTH);
      tick();
      if (accepted) pushed++;
      cyc++;
    end
    bus.s_vld = 1'b0; bus.cmd_rdy = 1'b0;
    checks++; if (dut_out.size() != 10) begin errors++; $display("FAIL wrap_len: got %0d want 10 after %0d cycles", dut_out.size(), cyc); end
    for (int k = 0; k < dut_out.size() && k < 10; k++) begin
      w = {1'b0, AWID'(4 * k), DW'(0)};
      checks++; if (dut_out[k] !== w) begin errors++; $display("FAIL wrap_seq[%0d]: got %h want %h", k, dut_out[k], w); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_enable_reset();
    logic [CW-1:0] head;
    logic [CW-1:0] w;
    clear_logs();
    bus.cmd_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.s_vld = 1'b1; bus.s_cmd = rand_cmd();
      tick();
    end
    bus.s_vld = 1'b0; bus.en = 1'b0;
    head = model_q[0];
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.transfer !== 1'b0 || bus.cmd_vld !== 1'b1 || bus.cmd_in !== head) begin errors++; $display("FAIL en_hold[%0d]: got xfer=%b vld=%b cmd=%h want xfer=0 vld=1 cmd=%h", k, bus.transfer, bus.cmd_vld, bus.cmd_in, head); end
    end
    checks++; if (bus.count !== 2'd3) begin errors++; $display("FAIL en_count: got %0d want 3", bus.count); end
    rst = 1'b1; bus.s_vld = 1'b1; bus.s_cmd = rand_cmd(); bus.cmd_rdy = 1'b1;
    tick();
    rst = 1'b0; bus.s_vld = 1'b0; bus.cmd_rdy = 1'b0; bus.en = 1'b1;
    checks++; if (bus.count !== '0 || bus.cmd_vld !== 1'b0 || bus.cmd_in !== '0 || bus.empty !== 1'b1) begin errors++; $display("FAIL midrst_state: got count=%0d vld=%b cmd=%h empty=%b want 0 0 0 1", bus.count, bus.cmd_vld, bus.cmd_in, bus.empty); end
    w = rand_cmd();
    bus.s_vld = 1'b1; bus.s_cmd = w;
    tick();
    bus.s_vld = 1'b0;
    checks++; if (bus.cmd_in !== w || bus.cmd_vld !== 1'b1 || bus.transfer !== 1'b1) begin errors++; $display("FAIL midrst_head: got cmd=%h vld=%b xfer=%b want cmd=%h vld=1 xfer=1", bus.cmd_in, bus.cmd_vld, bus.transfer, w); end
    checks++; if (bus.count !== CNTW'(model_q.size())) begin errors++; $display("FAIL midrst_count: got %0d want %0d", bus.count, model_q.size()); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.s_vld = 1'b0; bus.s_cmd = '0; bus.cmd_rdy = 1'b0; bus.en = 1'b1;
    test_reset();
    test_fill_drain();
    test_backpressure();
    test_concurrent();
    test_wrap();
    test_enable_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
